// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the writeback entry layout used
// between the execute stage and register-file writeback.
package cpu_pkg;

  localparam int DATA_W  = 8;
  localparam int RADDR_W = 3;
  localparam int FLAG_W  = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [FLAG_W-1:0]  flags;
    logic [RADDR_W-1:0] rd;
    logic               rd_we;
    logic               flags_we;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/ex_wb_stage_if.sv
// Execute/writeback/bypass signal bundle. The stage uses the slave modport;
// the execute side and register file together form the master side.
interface ex_wb_stage_if;

  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [cpu_pkg::DATA_W-1:0]   in_result;
  logic [cpu_pkg::FLAG_W-1:0]   in_flags;
  logic [cpu_pkg::RADDR_W-1:0]  in_rd;
  logic                         in_rd_we;
  logic                         in_flags_we;
  logic                         wb_valid;
  logic                         wb_ready;
  logic [cpu_pkg::RADDR_W-1:0]  wb_rd;
  logic [cpu_pkg::DATA_W-1:0]   wb_data;
  logic                         wb_we;
  logic [cpu_pkg::FLAG_W-1:0]   flags;
  logic [cpu_pkg::RADDR_W-1:0]  fwd_rs;
  logic                         fwd_hit;
  logic [cpu_pkg::DATA_W-1:0]   fwd_data;

  modport slave (
    input  flush, in_valid, in_result, in_flags, in_rd, in_rd_we, in_flags_we,
           wb_ready, fwd_rs,
    output in_ready, wb_valid, wb_rd, wb_data, wb_we, flags, fwd_hit, fwd_data
  );

  modport master (
    output flush, in_valid, in_result, in_flags, in_rd, in_rd_we, in_flags_we,
           wb_ready, fwd_rs,
    input  in_ready, wb_valid, wb_rd, wb_data, wb_we, flags, fwd_hit, fwd_data
  );

endinterface

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready buffer: slot 0 is the oldest (head), slot 1 the skid.
// in_ready is registered so there is no combinational path from out_ready.
module skid_buffer2 #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [W-1:0]      in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [W-1:0]      out_data_o,
  output logic [1:0]        ent_valid_o,
  output logic [1:0][W-1:0] ent_data_o
);

  logic         vld0_q, vld0_d;
  logic         vld1_q, vld1_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] dat0_q, dat0_d;
  logic [W-1:0] dat1_q, dat1_d;
  logic         push, pop;

  assign push = in_valid_i & rdy_q & ~clr_i;
  assign pop  = vld0_q & out_ready_i & ~clr_i;

  always_comb begin
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    if (clr_i) begin
      vld0_d = 1'b0;
      vld1_d = 1'b0;
    end else if (push && pop) begin
      if (vld1_q) begin
        dat0_d = dat1_q;
        dat1_d = in_data_i;
      end else begin
        dat0_d = in_data_i;
      end
    end else if (pop) begin
      dat0_d = dat1_q;
      vld0_d = vld1_q;
      vld1_d = 1'b0;
    end else if (push) begin
      if (vld0_q) begin
        dat1_d = in_data_i;
        vld1_d = 1'b1;
      end else begin
        dat0_d = in_data_i;
        vld0_d = 1'b1;
      end
    end
    // Slots fill in order, so occupancy < 2 is simply "skid slot empty".
    rdy_d = ~vld1_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      rdy_q  <= 1'b1;
      dat0_q <= '0;
      dat1_q <= '0;
    end else begin
      vld0_q <= vld0_d;
      vld1_q <= vld1_d;
      rdy_q  <= rdy_d;
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = vld0_q;
  assign out_data_o  = dat0_q;
  assign ent_valid_o = {vld1_q, vld0_q};
  assign ent_data_o  = {dat1_q, dat0_q};

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: buffers ALU results, drives register writeback,
// holds the architectural flags and supplies a one-port operand bypass.
module ex_wb_stage
  import cpu_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  ex_wb_stage_if.slave bus
);

  wb_entry_t                 in_ent;
  wb_entry_t                 head;
  wb_entry_t                 ent [2];
  logic                      head_vld;
  logic                      retire;
  logic [1:0]                ent_vld;
  logic [1:0][ENTRY_W-1:0]   ent_raw;
  logic [ENTRY_W-1:0]        head_raw;
  logic [FLAG_W-1:0]         flags_q, flags_d;
  logic                      fwd_hit_c;
  logic [DATA_W-1:0]         fwd_data_c;

  assign in_ent = '{result:   bus.in_result,
                    flags:    bus.in_flags,
                    rd:       bus.in_rd,
                    rd_we:    bus.in_rd_we,
                    flags_we: bus.in_flags_we};

  skid_buffer2 #(.W(ENTRY_W)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (bus.flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (in_ent),
    .out_valid_o (head_vld),
    .out_ready_i (bus.wb_ready),
    .out_data_o  (head_raw),
    .ent_valid_o (ent_vld),
    .ent_data_o  (ent_raw)
  );

  assign head = wb_entry_t'(head_raw);

  // Flush suppresses the retire even when the register file is ready.
  assign retire = head_vld & bus.wb_ready & ~bus.flush;

  always_comb begin
    flags_d = flags_q;
    if (retire && head.flags_we) flags_d = head.flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign bus.flags    = flags_q;
  assign bus.wb_valid = head_vld;
  assign bus.wb_rd    = head_vld ? head.rd     : '0;
  assign bus.wb_data  = head_vld ? head.result : '0;
  assign bus.wb_we    = head_vld & head.rd_we;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    for (int i = 0; i < 2; i++) begin
      ent[i] = wb_entry_t'(ent_raw[i]);
      if (ent_vld[i] && ent[i].rd_we && (ent[i].rd == bus.fwd_rs)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = ent[i].result;
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit_c;
  assign bus.fwd_data = fwd_data_c;

endmodule
